// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and constants for the truth-table response checker
package tt_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam logic [NUM_VEC-1:0] ALL_COVERED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tt_state_e;

  function automatic logic [NUM_VEC-1:0] vec_onehot(input logic [VEC_W-1:0] vec);
    vec_onehot = NUM_VEC'(1) << vec;
  endfunction

endpackage

// File: rtl/tt_idle_timer.sv
// rtl/tt_idle_timer.sv - counts idle cycles and flags the last one before a forced finish
module tt_idle_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);

  // Holds at LAST so a disabled timeout (TIMEOUT == 0) never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_last) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (TIMEOUT != 0) && i_enable && w_at_last;

endmodule

// File: rtl/tt_response_checker.sv
// rtl/tt_response_checker.sv - compares (vector, f) samples against an expected 4-input truth table
module tt_response_checker
  import tt_pkg::*;
#(
  parameter logic [15:0] EXPECTED_TT = 16'h0000,
  parameter int          CNT_W       = 5,
  parameter int          TIMEOUT     = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [VEC_W-1:0]   i_in_vec,
  input  logic               i_in_f,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [CNT_W-1:0]   o_mismatch_count,
  output logic               o_first_err_valid,
  output logic [VEC_W-1:0]   o_first_err_vec,
  output logic               o_first_err_got,
  output logic [NUM_VEC-1:0] o_coverage,
  output logic [NUM_VEC-1:0] o_observed_tt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  tt_state_e r_state;
  tt_state_e w_state_next;

  logic [NUM_VEC-1:0] r_coverage;
  logic [NUM_VEC-1:0] r_observed_tt;
  logic [CNT_W-1:0]   r_mismatch_count;
  logic               r_first_err_valid;
  logic [VEC_W-1:0]   r_first_err_vec;
  logic               r_first_err_got;
  logic               r_timeout;

  logic               w_run;
  logic               w_done;
  logic               w_take;
  logic               w_mismatch;
  logic               w_cov_full;
  logic               w_expired;
  logic [NUM_VEC-1:0] w_vec_onehot;

  assign w_run  = (r_state == ST_RUN);
  assign w_done = (r_state == ST_DONE);

  // A start on the same edge as a sample discards the sample.
  assign w_take       = i_in_valid & w_run & ~i_start;
  assign w_vec_onehot = vec_onehot(i_in_vec);
  assign w_mismatch   = (i_in_f != EXPECTED_TT[i_in_vec]);
  assign w_cov_full   = ((r_coverage | w_vec_onehot) == ALL_COVERED);

  tt_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (i_start | w_take),
    .i_enable  (w_run),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_start) begin
          w_state_next = ST_RUN;
        end else if (w_take && w_cov_full) begin
          w_state_next = ST_DONE;
        end else if (!w_take && w_expired) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_start) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      r_coverage        <= '0;
      r_observed_tt     <= '0;
      r_mismatch_count  <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_vec   <= '0;
      r_first_err_got   <= 1'b0;
      r_timeout         <= 1'b0;
    end else if (w_take) begin
      r_coverage              <= r_coverage | w_vec_onehot;
      r_observed_tt[i_in_vec] <= i_in_f;
      if (w_mismatch) begin
        if (r_mismatch_count != CNT_MAX) begin
          r_mismatch_count <= r_mismatch_count + CNT_W'(1);
        end
        if (!r_first_err_valid) begin
          r_first_err_valid <= 1'b1;
          r_first_err_vec   <= i_in_vec;
          r_first_err_got   <= i_in_f;
        end
      end
    end else if (w_expired) begin
      r_timeout <= 1'b1;
    end
  end

  assign o_in_ready        = w_run;
  assign o_busy            = w_run;
  assign o_done            = w_done;
  assign o_pass            = w_done & ~r_timeout & (r_mismatch_count == '0);
  assign o_timeout         = r_timeout;
  assign o_mismatch_count  = r_mismatch_count;
  assign o_first_err_valid = r_first_err_valid;
  assign o_first_err_vec   = r_first_err_vec;
  assign o_first_err_got   = r_first_err_got;
  assign o_coverage        = r_coverage;
  assign o_observed_tt     = r_observed_tt;

endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Sequential response checker for 4-input single-output logic functions; it is the receiving end of the exhaustive stimulus sweep.
- It accepts a stream of (input vector, observed f) samples over a valid/ready handshake and compares each against a parameterised expected truth table.
- It tracks which of the 16 vectors have been seen, and reports done, pass, a mismatch count and the first failing vector.
- It sits beside any combinational function under test, in hardware or in a bench.

Parameters:
- EXPECTED_TT, 16'h0000, expected truth table; bit i = expected f for vector i, where i = {a,b,c,d} and a is the MSB.
- CNT_W, 5, width of mismatch_count; the counter saturates at 2^CNT_W-1.
- TIMEOUT, 64, idle cycles in RUN with no accepted sample before a forced finish; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse; clears all results and enters RUN.
- in_valid  input  1  sample present.
- in_ready  output  1  checker accepts a sample this cycle.
- in_vec  input  4  applied vector {a,b,c,d}.
- in_f  input  1  observed function output for in_vec.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  done, no timeout, and zero mismatches.
- timeout  output  1  DONE was reached by timeout.
- mismatch_count  output  CNT_W  number of mismatching accepted samples.
- first_err_valid  output  1  a first mismatch has been captured.
- first_err_vec  output  4  vector of the first mismatch.
- first_err_got  output  1  observed f at the first mismatch.
- coverage  output  16  bit i set once vector i has been accepted.
- observed_tt  output  16  bit i = last observed f for vector i.

Behaviour:
- Reset: clk and a synchronous active-high rst. With rst high at a rising edge:
  - state <= IDLE.
  - All outputs 0: coverage, observed_tt, mismatch_count, first_err_*, timeout, and the idle counter.
- States: IDLE, RUN, DONE.
- State outputs: in_ready = busy = (state==RUN); done = (state==DONE).
- Transitions:
  - IDLE --start--> RUN.
  - RUN --coverage complete or timeout--> DONE.
  - DONE --start--> RUN.
- On every start edge, from any state including RUN:
  - clear coverage, observed_tt, mismatch_count, first_err_*, timeout and the idle counter;
  - enter RUN.
- Start in RUN restarts the run. If in_valid is also high on that edge, start wins and the sample is discarded.
- Accept = in_valid & in_ready. On an accept edge:
  - coverage[in_vec] <= 1;
  - observed_tt[in_vec] <= in_f;
  - mismatch = (in_f != EXPECTED_TT[in_vec]).
- On mismatch:
  - mismatch_count increments, saturating at all-ones with no wrap;
  - if first_err_valid is 0: capture first_err_vec and first_err_got, and set first_err_valid.
- Duplicate vectors are re-compared and counted again; coverage is unchanged and observed_tt is overwritten.
- Latency: every result of an accept is visible in the cycle after the accept edge.
- Coverage completion: when the accept makes coverage 16'hFFFF, state <= DONE on the same edge. done rises in the next cycle, and in_ready drops in that same cycle.
- Idle counter (RUN only):
  - resets to 0 on an accept;
  - otherwise increments each cycle.
- Timeout (TIMEOUT != 0): when the counter reaches TIMEOUT-1 with no accept, then on the next edge state <= DONE and timeout <= 1.
- Simultaneous accept and timeout on the same edge: the accept wins and the counter clears.
- pass is combinational: done & ~timeout & (mismatch_count==0).
- In IDLE and DONE, in_valid is ignored and results hold until start or rst.
- rst mid-run aborts the run immediately. Partial results are lost.

Decomposition:
- Shared package tt_pkg:
  - state typedef (IDLE/RUN/DONE);
  - VEC_W=4;
  - NUM_VEC=16;
  - ALL_COVERED=16'hFFFF.
- One sub-module, tt_idle_timer: parameter TIMEOUT; inputs clk, rst, clear, enable; output expired.
- The compare, scoreboard and FSM stay in tt_response_checker.

Test Plan:
- Pass run: EXPECTED_TT=16'hA5C3. After start, feed vectors 0..15 in order, each with in_f=EXPECTED_TT[i] and in_valid held high. Required:
  - done rises the cycle after the 16th accept;
  - pass=1, mismatch_count=0, coverage=16'hFFFF, observed_tt=16'hA5C3.
- Single error: the same sweep, but vector 5 sent with in_f=1 (expected 0). Required:
  - mismatch_count=1, first_err_vec=5, first_err_got=1, pass=0;
  - observed_tt=16'hA5E3.
- Duplicates and saturation: CNT_W=2; send vector 3 with the wrong f six times. Required:
  - mismatch_count saturates at 3;
  - coverage=16'h0008;
  - first_err_vec=3 is unchanged after the first capture.
- Timeout: TIMEOUT=8; accept vectors 0..9, then drop in_valid. Required:
  - DONE is entered 8 cycles after the last accept, with timeout=1 and pass=0;
  - coverage=16'h03FF.
- Restart mid-run: start plus in_valid (vector 7) asserted on the same edge during RUN. Required:
  - all results cleared, vector 7 not recorded, state RUN.
- Reset mid-run: rst high for 1 cycle after 4 accepts. Required:
  - state IDLE, all outputs 0, in_ready=0;
  - subsequent in_valid ignored until start.
